akumulator_bank: RTL and testbench

Parametrised accumulator bank for the microprocessor datapath: `NUM_ACC` independent accumulators of `DATA_W` bits with registered status flags (carry, zero, negative), shift/rotate operations and a hardware LIFO save stack for context push/pop. It sits between the ALU result bus and the ALU A-operand input. It replaces the single-register, load-only accumulator.

---
 rtl/akumulator_pkg.sv | 20 ++
 rtl/akum_stack.sv | 56 +++++
 rtl/akumulator_bank.sv | 105 ++++++++++
 tb/tb_akumulator_bank.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/akumulator_pkg.sv
// Shared definitions for the accumulator bank: opcode enum and flag bit positions.
package akumulator_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_CLR  = 3'd2,
    OP_SHL  = 3'd3,
    OP_SHR  = 3'd4,
    OP_ROLC = 3'd5,
    OP_PUSH = 3'd6,
    OP_POP  = 3'd7
  } op_t;

  localparam int FLAG_C    = 0;
  localparam int FLAG_Z    = 1;
  localparam int FLAG_N    = 2;
  localparam int NUM_FLAGS = 3;

endpackage

// File: rtl/akum_stack.sv
// LIFO save stack for accumulator context push/pop; overflow/underflow attempts
// are refused and reported with a one-cycle err pulse.
module akum_stack #(
  parameter int DATA_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic              err
);

  localparam int SP_W   = $clog2(STACK_DEPTH + 1);
  localparam int ADDR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SP_W-1:0]   r_sp;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  logic              w_full;
  logic              w_empty;
  logic [ADDR_W-1:0] w_wr_idx;
  logic [ADDR_W-1:0] w_rd_idx;

  assign w_full   = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty  = (r_sp == '0);
  assign w_wr_idx = r_sp[ADDR_W-1:0];
  assign w_rd_idx = ADDR_W'(r_sp - 1'b1);

  // Contents survive reset; only the pointer is cleared.
  always_ff @(posedge clk) begin
    if (!rst && push && !w_full) r_mem[w_wr_idx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp  <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= (push && w_full) || (pop && w_empty);
      if (push && !w_full)      r_sp <= r_sp + 1'b1;
      else if (pop && !w_empty) r_sp <= r_sp - 1'b1;
    end
  end

  assign rdata = w_empty ? '0 : r_mem[w_rd_idx];
  assign full  = w_full;
  assign empty = w_empty;
  assign err   = r_err;

endmodule

// File: rtl/akumulator_bank.sv
// Bank of NUM_ACC accumulators with shared carry/zero/neg flags, shift/rotate
// ops and a LIFO save stack; out is a combinational read of acc[sel].
module akumulator_bank
  import akumulator_pkg::*;
#(
  parameter  int DATA_W      = 8,
  parameter  int NUM_ACC     = 4,
  parameter  int STACK_DEPTH = 4,
  localparam int SEL_W       = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [2:0]        op,
  input  logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] out,
  output logic              carry,
  output logic              zero,
  output logic              neg,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              err
);

  logic [DATA_W-1:0]    r_acc [NUM_ACC];
  logic [NUM_FLAGS-1:0] r_flags;

  op_t               w_op;
  logic              w_sel_ok;
  logic              w_act;
  logic [DATA_W-1:0] w_cur;
  logic [DATA_W-1:0] w_nxt;
  logic              w_cnxt;
  logic              w_wr;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_st_rdata;
  logic              w_st_full;
  logic              w_st_empty;
  logic              w_st_err;

  assign w_op     = op_t'(op);
  assign w_sel_ok = ({1'b0, sel} < (SEL_W + 1)'(NUM_ACC));
  assign w_act    = ce && w_sel_ok;
  assign w_cur    = w_sel_ok ? r_acc[sel] : '0;
  assign w_push   = w_act && (w_op == OP_PUSH);
  assign w_pop    = w_act && (w_op == OP_POP);

  always_comb begin
    w_nxt  = w_cur;
    w_cnxt = r_flags[FLAG_C];
    w_wr   = 1'b0;
    if (w_act) begin
      unique case (w_op)
        OP_LOAD: begin w_wr = 1'b1; w_nxt = d_in; end
        OP_CLR:  begin w_wr = 1'b1; w_nxt = '0; w_cnxt = 1'b0; end
        OP_SHL:  begin w_wr = 1'b1; w_nxt = {w_cur[DATA_W-2:0], 1'b0};
                       w_cnxt = w_cur[DATA_W-1]; end
        OP_SHR:  begin w_wr = 1'b1; w_nxt = {1'b0, w_cur[DATA_W-1:1]};
                       w_cnxt = w_cur[0]; end
        OP_ROLC: begin w_wr = 1'b1; w_nxt = {w_cur[DATA_W-2:0], r_flags[FLAG_C]};
                       w_cnxt = w_cur[DATA_W-1]; end
        OP_POP:  if (!w_st_empty) begin w_wr = 1'b1; w_nxt = w_st_rdata; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ACC; i++) r_acc[i] <= '0;
      r_flags <= '0;
    end else if (w_wr) begin
      r_acc[sel]      <= w_nxt;
      r_flags[FLAG_C] <= w_cnxt;
      r_flags[FLAG_Z] <= (w_nxt == '0);
      r_flags[FLAG_N] <= w_nxt[DATA_W-1];
    end
  end

  akum_stack #(
    .DATA_W      (DATA_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_cur),
    .rdata (w_st_rdata),
    .full  (w_st_full),
    .empty (w_st_empty),
    .err   (w_st_err)
  );

  assign out         = w_cur;
  assign carry       = r_flags[FLAG_C];
  assign zero        = r_flags[FLAG_Z];
  assign neg         = r_flags[FLAG_N];
  assign stack_full  = w_st_full;
  assign stack_empty = w_st_empty;
  assign err         = w_st_err;

endmodule

// File: tb/tb_akumulator_bank.sv
// Directed bench for akumulator_bank: default 4-accumulator instance plus a
// 3-accumulator instance sharing the stimulus for the out-of-range select case.
module tb_akumulator_bank;
  import akumulator_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce  = 1'b0;
  logic [2:0] op  = 3'd0;
  logic [1:0] sel = 2'd0;
  logic [7:0] d_in = 8'h00;

  logic [7:0] out4, out3;
  logic c4, z4, n4, f4, e4, er4;
  logic c3, z3, n3, f3, e3, er3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  akumulator_bank #(.DATA_W(8), .NUM_ACC(4), .STACK_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .ce(ce), .op(op), .sel(sel), .d_in(d_in),
    .out(out4), .carry(c4), .zero(z4), .neg(n4),
    .stack_full(f4), .stack_empty(e4), .err(er4)
  );

  akumulator_bank #(.DATA_W(8), .NUM_ACC(3), .STACK_DEPTH(4)) u_dut3 (
    .clk(clk), .rst(rst), .ce(ce), .op(op), .sel(sel), .d_in(d_in),
    .out(out3), .carry(c3), .zero(z3), .neg(n3),
    .stack_full(f3), .stack_empty(e3), .err(er3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one operation, let it be sampled by a clock edge, settle past the edge.
  task automatic step(input logic c, input op_t o, input logic [1:0] s, input logic [7:0] d);
    ce = c; op = o; sel = s; d_in = d;
    @(posedge clk);
    #1;
  endtask

  // zero/neg/carry for the 4-acc instance in one call
  task automatic chk_flags(input string tag, input logic c, input logic z, input logic n);
    chk({tag, "_carry"}, {31'd0, c4}, {31'd0, c});
    chk({tag, "_zero"},  {31'd0, z4}, {31'd0, z});
    chk({tag, "_neg"},   {31'd0, n4}, {31'd0, n});
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    step(1'b0, OP_NOP, 2'd0, 8'h00);
    step(1'b0, OP_NOP, 2'd0, 8'h00);
    rst = 1'b0;
    chk("rst_out", {24'd0, out4}, 32'h00);
    chk_flags("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_empty", {31'd0, e4}, 32'd1);
    chk("rst_full",  {31'd0, f4}, 32'd0);
    chk("rst_err",   {31'd0, er4}, 32'd0);

    // LOAD sel=2 0x80
    step(1'b1, OP_LOAD, 2'd2, 8'h80);
    chk("load80_out", {24'd0, out4}, 32'h80);
    chk_flags("load80", 1'b0, 1'b0, 1'b1);
    ce = 1'b0; sel = 2'd0; #1;
    chk("sel0_comb", {24'd0, out4}, 32'h00);

    // SHL 0x80 -> 0x00 c=1 z=1; ROLC -> 0x01 c=0
    step(1'b1, OP_SHL, 2'd2, 8'h00);
    chk("shl_out", {24'd0, out4}, 32'h00);
    chk_flags("shl", 1'b1, 1'b1, 1'b0);
    step(1'b1, OP_ROLC, 2'd2, 8'h00);
    chk("rolc_out", {24'd0, out4}, 32'h01);
    chk_flags("rolc", 1'b0, 1'b0, 1'b0);

    // LOAD 0x81, SHR -> 0x40 c=1; CLR -> 0 c=0 z=1
    step(1'b1, OP_LOAD, 2'd2, 8'h81);
    chk_flags("load81", 1'b0, 1'b0, 1'b1);
    step(1'b1, OP_SHR, 2'd2, 8'h00);
    chk("shr_out", {24'd0, out4}, 32'h40);
    chk_flags("shr", 1'b1, 1'b0, 1'b0);
    step(1'b1, OP_CLR, 2'd2, 8'h00);
    chk("clr_out", {24'd0, out4}, 32'h00);
    chk_flags("clr", 1'b0, 1'b1, 1'b0);

    // Fill the stack from acc[0]
    step(1'b1, OP_LOAD, 2'd0, 8'h11); step(1'b1, OP_PUSH, 2'd0, 8'h00);
    chk("push1_empty", {31'd0, e4}, 32'd0);
    step(1'b1, OP_LOAD, 2'd0, 8'h22); step(1'b1, OP_PUSH, 2'd0, 8'h00);
    step(1'b1, OP_LOAD, 2'd0, 8'h33); step(1'b1, OP_PUSH, 2'd0, 8'h00);
    step(1'b1, OP_LOAD, 2'd0, 8'h44);
    chk("push3_full", {31'd0, f4}, 32'd0);
    step(1'b1, OP_PUSH, 2'd0, 8'h00);
    chk("push4_full", {31'd0, f4}, 32'd1);
    chk("push4_err",  {31'd0, er4}, 32'd0);
    chk("push_keeps_acc", {24'd0, out4}, 32'h44);
    step(1'b1, OP_PUSH, 2'd0, 8'h00);
    chk("ovf_err",  {31'd0, er4}, 32'd1);
    chk("ovf_full", {31'd0, f4}, 32'd1);
    step(1'b0, OP_NOP, 2'd0, 8'h00);
    chk("ovf_err_clear", {31'd0, er4}, 32'd0);

    // Drain into acc[1]
    step(1'b1, OP_POP, 2'd1, 8'h00);
    chk("pop1", {24'd0, out4}, 32'h44);
    chk("pop1_full", {31'd0, f4}, 32'd0);
    step(1'b1, OP_POP, 2'd1, 8'h00);
    chk("pop2", {24'd0, out4}, 32'h33);
    step(1'b1, OP_POP, 2'd1, 8'h00);
    chk("pop3", {24'd0, out4}, 32'h22);
    step(1'b1, OP_POP, 2'd1, 8'h00);
    chk("pop4", {24'd0, out4}, 32'h11);
    chk("pop4_empty", {31'd0, e4}, 32'd1);
    chk("pop4_err", {31'd0, er4}, 32'd0);
    step(1'b1, OP_POP, 2'd1, 8'h00);
    chk("unf_err", {31'd0, er4}, 32'd1);
    chk("unf_acc", {24'd0, out4}, 32'h11);
    chk_flags("unf", 1'b0, 1'b0, 1'b0);
    step(1'b0, OP_NOP, 2'd1, 8'h00);
    chk("unf_err_clear", {31'd0, er4}, 32'd0);

    // PUSH, POP, PUSH, POP back to back
    step(1'b1, OP_PUSH, 2'd1, 8'h00);
    step(1'b1, OP_POP, 2'd2, 8'h00);
    chk("b2b_pop", {24'd0, out4}, 32'h11);
    chk("b2b_empty", {31'd0, e4}, 32'd1);
    step(1'b1, OP_PUSH, 2'd2, 8'h00);
    chk("b2b_push_empty", {31'd0, e4}, 32'd0);
    step(1'b1, OP_POP, 2'd0, 8'h00);
    chk("b2b_pop0", {24'd0, out4}, 32'h11);
    chk("b2b_pop0_empty", {31'd0, e4}, 32'd1);

    // ce=0 with LOAD: no change
    step(1'b1, OP_SHL, 2'd2, 8'h00);   // acc2 0x11 -> 0x22, carry 0
    step(1'b0, OP_LOAD, 2'd1, 8'hAA);
    chk("ce0_out", {24'd0, out4}, 32'h11);
    chk_flags("ce0", 1'b0, 1'b0, 1'b0);

    // rst together with LOAD 0xFF
    rst = 1'b1;
    step(1'b1, OP_LOAD, 2'd1, 8'hFF);
    rst = 1'b0;
    chk("rstop_out", {24'd0, out4}, 32'h00);
    chk("rstop_empty", {31'd0, e4}, 32'd1);
    chk_flags("rstop", 1'b0, 1'b0, 1'b0);
    sel = 2'd2; #1;
    chk("rstop_acc2", {24'd0, out4}, 32'h00);

    // sel=3: valid on 4-acc instance, ignored on 3-acc instance
    step(1'b1, OP_LOAD, 2'd3, 8'hFF);
    chk("sel3_out4", {24'd0, out4}, 32'hFF);
    chk("sel3_out3", {24'd0, out3}, 32'h00);
    chk("sel3_neg3", {31'd0, n3}, 32'd0);
    chk("sel3_err3", {31'd0, er3}, 32'd0);
    step(1'b1, OP_PUSH, 2'd3, 8'h00);
    chk("sel3_push_e4", {31'd0, e4}, 32'd0);
    chk("sel3_push_e3", {31'd0, e3}, 32'd1);
    step(1'b1, OP_POP, 2'd3, 8'h00);
    chk("sel3_pop_err3", {31'd0, er3}, 32'd0);
    chk("sel3_pop_z3", {31'd0, z3}, 32'd0);
    step(1'b0, OP_NOP, 2'd2, 8'h00);
    chk("sel2_out3", {24'd0, out3}, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
